// File: rtl/oc_if.sv
// Bus between the systolic-array row output, the ping-pong output buffer and the DDR reader.
// Handshake: a sample is taken when row_valid_out && wrdy; a word is requested when rd_en && rrdy, and returns next cycle with dout_valid.
interface oc_if #(
  parameter int Data_width = 8,
  parameter int DDR_width  = 128
);
  logic [Data_width-1:0] row_data_out;
  logic                  row_valid_out;
  logic                  row_last;
  logic                  wrdy;
  logic                  rd_en;
  logic                  rrdy;
  logic [DDR_width-1:0]  dout;
  logic                  dout_valid;
  logic                  rlast;
  logic                  overflow;
  logic [1:0]            wstate;

  modport master (
    output row_data_out, row_valid_out, row_last, rd_en,
    input  wrdy, rrdy, dout, dout_valid, rlast, overflow, wstate
  );

  modport slave (
    input  row_data_out, row_valid_out, row_last, rd_en,
    output wrdy, rrdy, dout, dout_valid, rlast, overflow, wstate
  );
endinterface

// File: rtl/oc.sv
// Output collector: packs SA row samples into DDR words and buffers them in two
// ping-pong banks that the DDR side drains strictly alternately.
module oc #(
  parameter int Data_width = 8,
  parameter int DDR_width  = 128,
  parameter int BANK_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  oc_if.slave bus
);
  localparam int LANES = DDR_width / Data_width;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = $clog2(BANK_DEPTH);
  localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);
  localparam logic [AW-1:0] PTR_MAX  = AW'(BANK_DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {W0 = 2'd0, W1 = 2'd1, WFULL = 2'd2} wstate_t;

  wstate_t              wstate;
  logic [LW-1:0]        lane_cnt;
  logic [DDR_width-1:0] asm_reg;
  logic [DDR_width-1:0] asm_next;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          bank_cnt [2];
  logic [1:0]           bank_closed;
  logic                 rd_bank;
  logic [DDR_width-1:0] mem [2*BANK_DEPTH];

  logic                 wr_bank, accept, commit, close;
  logic                 rd_fire, rd_last, other_free;
  logic [1:0]           close_mask, free_mask;
  logic [DDR_width-1:0] dout_r;
  logic                 dv_r, rlast_r, ovf_r;

  always_comb begin
    wr_bank  = (wstate == W1);
    accept   = bus.row_valid_out && (wstate != WFULL);
    commit   = accept && ((lane_cnt == LANE_MAX) || bus.row_last);
    close    = commit && ((wr_ptr == PTR_MAX) || bus.row_last);
    asm_next = asm_reg;
    asm_next[lane_cnt*Data_width +: Data_width] = bus.row_data_out;
    rd_fire  = bus.rd_en && bank_closed[rd_bank];
    rd_last  = rd_fire && ({1'b0, rd_ptr} == (bank_cnt[rd_bank] - CNT_ONE));
    // The other bank counts as free if the reader releases it on this same edge.
    other_free = !bank_closed[!wr_bank] || (rd_last && (rd_bank == !wr_bank));
    close_mask = {close && wr_bank, close && !wr_bank};
    free_mask  = {rd_last && rd_bank, rd_last && !rd_bank};
  end

  // Bank storage is deliberately not reset; bank_closed gates every read.
  always_ff @(posedge clk) begin
    if (!rst && commit) mem[{wr_bank, wr_ptr}] <= asm_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate      <= W0;
      lane_cnt    <= '0;
      asm_reg     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_bank     <= 1'b0;
      bank_closed <= '0;
      bank_cnt[0] <= '0;
      bank_cnt[1] <= '0;
      dout_r      <= '0;
      dv_r        <= 1'b0;
      rlast_r     <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      if (bus.row_valid_out && (wstate == WFULL)) ovf_r <= 1'b1;
      if (accept) begin
        lane_cnt <= commit ? '0 : lane_cnt + 1'b1;
        asm_reg  <= commit ? '0 : asm_next;
      end
      if (commit) wr_ptr <= close ? '0 : wr_ptr + 1'b1;
      if (close) bank_cnt[wr_bank] <= {1'b0, wr_ptr} + CNT_ONE;
      bank_closed <= (bank_closed | close_mask) & ~free_mask;

      case (wstate)
        W0, W1:  if (close) wstate <= other_free ? (wr_bank ? W0 : W1) : WFULL;
        WFULL:   if (rd_last) wstate <= rd_bank ? W1 : W0;
        default: wstate <= W0;
      endcase

      if (rd_fire) begin
        dout_r  <= mem[{rd_bank, rd_ptr}];
        dv_r    <= 1'b1;
        rlast_r <= rd_last;
        rd_ptr  <= rd_last ? '0 : rd_ptr + 1'b1;
        if (rd_last) rd_bank <= !rd_bank;
      end else begin
        dv_r    <= 1'b0;
        rlast_r <= 1'b0;
      end
    end
  end

  assign bus.wrdy       = (wstate != WFULL);
  assign bus.rrdy       = bank_closed[rd_bank];
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dv_r;
  assign bus.rlast      = rlast_r;
  assign bus.overflow   = ovf_r;
  assign bus.wstate     = wstate;
endmodule

// File: tb/tb_oc.sv
// Bench for oc: reset checks, overflow and bank-crossing reads, mid-run reset,
// ignored reads, streaming, and a table of single-bank tiles.
module tb_oc;
  localparam int DW    = 8;
  localparam int DDRW  = 128;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oc_if #(.Data_width(DW), .DDR_width(DDRW)) bus ();
  oc #(.Data_width(DW), .DDR_width(DDRW), .BANK_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DDRW-1:0] exp_q[$];

  typedef struct {
    int              n;
    logic [7:0]      base;
    logic            use_last;
    int              nwords;
    logic [DDRW-1:0] first_w;
    logic [DDRW-1:0] last_w;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [DDRW-1:0] act, input logic [DDRW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.row_valid_out = 1'b0;
    bus.row_last      = 1'b0;
    bus.row_data_out  = '0;
    bus.rd_en         = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wrdy"},   DDRW'(bus.wrdy), 1);
    chk({tag, "_rrdy"},   DDRW'(bus.rrdy), 0);
    chk({tag, "_dout"},   bus.dout, 0);
    chk({tag, "_dv"},     DDRW'(bus.dout_valid), 0);
    chk({tag, "_rlast"},  DDRW'(bus.rlast), 0);
    chk({tag, "_ovf"},    DDRW'(bus.overflow), 0);
    chk({tag, "_wstate"}, DDRW'(bus.wstate), 0);
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    bus.row_valid_out = 1'b1;
    bus.row_data_out  = d;
    bus.row_last      = last;
    tick();
    bus.row_valid_out = 1'b0;
    bus.row_last      = 1'b0;
  endtask

  // Reference packing: lane k holds base+k for the first n lanes, the rest zero.
  function automatic logic [DDRW-1:0] pack(input logic [7:0] base, input int n);
    logic [DDRW-1:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*DW +: DW] = base + 8'(k);
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DDRW-1:0] e;
    int got;
    vecs[0] = '{64, 8'h00, 1'b0, 4, 128'h0F0E0D0C0B0A09080706050403020100, 128'h3F3E3D3C3B3A39383736353433323130};
    vecs[1] = '{20, 8'h00, 1'b1, 2, 128'h0F0E0D0C0B0A09080706050403020100, 128'h00000000000000000000000013121110};
    vecs[2] = '{1,  8'hA5, 1'b1, 1, 128'h000000000000000000000000000000A5, 128'h000000000000000000000000000000A5};
    vecs[3] = '{32, 8'h80, 1'b1, 2, 128'h8F8E8D8C8B8A89888786858483828180, 128'h9F9E9D9C9B9A99989796959493929190};
    vecs[4] = '{17, 8'h40, 1'b1, 2, 128'h4F4E4D4C4B4A49484746454443424140, 128'h00000000000000000000000000000050};

    idle();
    rst = 1'b1;
    do_reset();
    check_reset("init");

    // Fill both banks, overflow with two extra samples, then drain back to back.
    for (int i = 0; i < 130; i++) begin
      if (i == 127) chk("ovfl_wrdy_before_full", DDRW'(bus.wrdy), 1);
      if (i == 128) begin
        chk("ovfl_wrdy_full", DDRW'(bus.wrdy), 0);
        chk("ovfl_flag_before_drop", DDRW'(bus.overflow), 0);
      end
      push(8'(i), 1'b0);
    end
    chk("ovfl_flag_set", DDRW'(bus.overflow), 1);
    chk("ovfl_rrdy", DDRW'(bus.rrdy), 1);
    for (int w = 0; w < 8; w++) exp_q.push_back(pack(8'(16*w), 16));
    for (int w = 0; w < 8; w++) begin
      bus.rd_en = 1'b1;
      tick();
      chk($sformatf("ovfl_dv_w%0d", w), DDRW'(bus.dout_valid), 1);
      e = exp_q.pop_front();
      chk($sformatf("ovfl_dout_w%0d", w), bus.dout, e);
      chk($sformatf("ovfl_rlast_w%0d", w), DDRW'(bus.rlast), DDRW'((w == 3) || (w == 7)));
      if (w == 2) chk("ovfl_wrdy_still_full", DDRW'(bus.wrdy), 0);
      if (w == 3) chk("ovfl_wrdy_at_rlast", DDRW'(bus.wrdy), 1);
    end
    bus.rd_en = 1'b0;
    chk("ovfl_rrdy_after_drain", DDRW'(bus.rrdy), 0);
    chk("ovfl_flag_sticky", DDRW'(bus.overflow), 1);

    // Reset in the middle of a tile; inputs held active during rst are ignored.
    for (int i = 0; i < 30; i++) push(8'hC0 + 8'(i), 1'b0);
    rst = 1'b1;
    bus.row_valid_out = 1'b1;
    bus.row_data_out  = 8'hEE;
    bus.row_last      = 1'b1;
    bus.rd_en         = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check_reset("midrst");
    for (int i = 0; i < 64; i++) push(8'(i), 1'b0);
    for (int w = 0; w < 4; w++) begin
      bus.rd_en = 1'b1;
      tick();
      chk($sformatf("midrst_dout_w%0d", w), bus.dout, pack(8'(16*w), 16));
      chk($sformatf("midrst_rlast_w%0d", w), DDRW'(bus.rlast), DDRW'(w == 3));
    end
    bus.rd_en = 1'b0;

    // Read requests while nothing is readable.
    chk("noread_rrdy", DDRW'(bus.rrdy), 0);
    bus.rd_en = 1'b1;
    tick();
    chk("noread_dv", DDRW'(bus.dout_valid), 0);
    chk("noread_dout", bus.dout, 128'h3F3E3D3C3B3A39383736353433323130);
    bus.rd_en = 1'b0;
    tick();
    chk("noread_dout_hold", bus.dout, 128'h3F3E3D3C3B3A39383736353433323130);
    chk("noread_rlast", DDRW'(bus.rlast), 0);

    // Streaming: samples every cycle with rd_en held high throughout.
    do_reset();
    for (int w = 0; w < 16; w++) exp_q.push_back(pack(8'(16*w), 16));
    got = 0;
    bus.rd_en = 1'b1;
    for (int c = 0; c < 256 + 40; c++) begin
      bus.row_valid_out = (c < 256);
      bus.row_data_out  = 8'(c);
      tick();
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_word", bus.dout, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream_dout_w%0d", got), bus.dout, e);
        end
        got++;
      end
    end
    idle();
    chk("stream_word_count", DDRW'(got), 16);
    chk("stream_ovf", DDRW'(bus.overflow), 0);
    exp_q.delete();

    // Single-bank tiles from the vector table.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < vecs[r].n; i++) begin
        if (i == vecs[r].n - 1) chk($sformatf("row%0d_rrdy_open", r), DDRW'(bus.rrdy), 0);
        push(vecs[r].base + 8'(i), vecs[r].use_last && (i == vecs[r].n - 1));
      end
      chk($sformatf("row%0d_rrdy_closed", r), DDRW'(bus.rrdy), 1);
      chk($sformatf("row%0d_wrdy", r), DDRW'(bus.wrdy), 1);
      for (int w = 0; w < vecs[r].nwords; w++) begin
        int rem;
        rem = vecs[r].n - 16*w;
        if (w == 0) e = vecs[r].first_w;
        else if (w == vecs[r].nwords - 1) e = vecs[r].last_w;
        else e = pack(vecs[r].base + 8'(16*w), (rem > 16) ? 16 : rem);
        bus.rd_en = 1'b1;
        tick();
        chk($sformatf("row%0d_dv_w%0d", r, w), DDRW'(bus.dout_valid), 1);
        chk($sformatf("row%0d_dout_w%0d", r, w), bus.dout, e);
        chk($sformatf("row%0d_rlast_w%0d", r, w), DDRW'(bus.rlast), DDRW'(w == vecs[r].nwords - 1));
      end
      bus.rd_en = 1'b0;
      chk($sformatf("row%0d_rrdy_drained", r), DDRW'(bus.rrdy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/oc.md
OC -- requirements
Module: oc

Interface
REQ-001 SHALL have parameter Data_width, default 8: width of one sample from the systolic array.
REQ-002 SHALL have parameter DDR_width, default 128: width of a packed output word; LANES = DDR_width/Data_width (16).
REQ-003 SHALL have parameter BANK_DEPTH, default 4: words per ping-pong bank; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port row_data_out, input, Data_width bits: sample from the SA row output.
REQ-007 SHALL have port row_valid_out, input, 1 bit: qualifies row_data_out.
REQ-008 SHALL have port row_last, input, 1 bit: marks the last sample of a tile; meaningful only with row_valid_out.
REQ-009 SHALL have port wrdy, output, 1 bit: a bank is open for writing.
REQ-010 SHALL have port rd_en, input, 1 bit: DDR-side request for one word.
REQ-011 SHALL have port rrdy, output, 1 bit: a closed bank is readable.
REQ-012 SHALL have port dout, output, DDR_width bits: packed word.
REQ-013 SHALL have port dout_valid, output, 1 bit: qualifies dout.
REQ-014 SHALL have port rlast, output, 1 bit: high with dout_valid on the final word of a bank.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, a sample was dropped.

Function
REQ-016 SHALL accept a sample when row_valid_out=1 and wrdy=1.
REQ-017 SHALL pack accepted samples little-endian: lane k at bits [k*Data_width +: Data_width]; the first sample of a word goes to lane 0.
REQ-018 SHALL commit the assembled word into the open bank at the edge accepting lane LANES-1, or accepting a sample with row_last=1; unfilled lanes SHALL be zero; lane counter and assembly register SHALL then clear.
REQ-019 SHALL close the open bank when it holds BANK_DEPTH words, or on a row_last commit; each bank SHALL record its word count (1..BANK_DEPTH).
REQ-020 SHALL implement write FSM states W0, W1 and WFULL; W0/W1 write bank0/bank1; on close, go to the other bank if free, else WFULL; WFULL exits to the bank the reader frees.
REQ-021 SHALL drive wrdy=1 in W0/W1 and wrdy=0 in WFULL.
REQ-022 SHALL drop a sample presented with row_valid_out=1 and wrdy=0, and set overflow=1 from the next edge until rst.
REQ-023 SHALL read banks strictly alternately, starting with bank0; rrdy=1 iff the current read bank is closed.
REQ-024 SHALL, on rd_en=1 and rrdy=1 at edge t, present the next word on dout with dout_valid=1 at t+1 (one-cycle latency, registered).
REQ-025 SHALL, when the last counted word of a bank is issued, assert rlast with it, free that bank at the same edge, and toggle the read bank.
REQ-026 SHALL ignore rd_en while rrdy=0; dout_valid=0 next cycle.
REQ-027 SHALL hold dout at its last value while dout_valid=0.
REQ-028 SHALL sustain one word per cycle under continuous rd_en, crossing banks without a bubble when the next bank is closed.
REQ-029 SHALL apply a same-edge bank close and bank free both; if the close would enter WFULL, the write FSM SHALL go directly to the freed bank.

Reset
REQ-030 SHALL, at an edge with rst=1: write FSM W0, read bank0, all counters and the assembly register 0, both banks free.
REQ-031 SHALL drive wrdy=1, rrdy=0, dout=0, dout_valid=0, rlast=0 and overflow=0 after reset; bank storage need not clear.
REQ-032 SHALL ignore inputs during rst; a reset mid-operation SHALL discard all buffered data.

Verification
REQ-033 SHALL cover: 64 samples 0x00..0x3F, then rd_en for 4 cycles -> rrdy=1 after the 64th; words 0x0F0E..0100 through 0x3F3E..3130; rlast on the 4th; then rrdy=0.
REQ-034 SHALL cover: 20 samples 0x00..0x13 with row_last on the 20th -> bank0 closes with 2 words; word1 = 0x13121110 in bits [31:0], rest zero; rlast on word1.
REQ-035 SHALL cover: 130 samples with no reads -> wrdy=0 after the 128th; samples 129-130 dropped; overflow=1; reading bank0 gives wrdy=1 in the rlast cycle.
REQ-036 SHALL cover: continuous writes with rd_en held high -> overflow=0, words in order, no dout_valid gap at bank crossings.
REQ-037 SHALL cover: rst after 30 samples, then 64 new samples -> reset values next cycle; first word read holds only new data.
REQ-038 SHALL cover: rd_en pulsed while rrdy=0 -> dout_valid=0 and dout unchanged.
